usr_seq_shifter: RTL and testbench

Parametrised universal shift register that executes multi-bit shift, rotate, load and clear commands through a valid/ready command port. Shifts advance one bit per clock under a small FSM, and the serial inputs are sampled live on each step. A `done` pulse marks completion. This is the successor to the fixed 8-bit, single-step universal shift register. It serves as the serialiser/deserialiser and bit-manipulation stage of the datapath.

---
 rtl/usr_pkg.sv | 32 +++
 rtl/usr_step.sv | 54 +++++
 rtl/usr_seq_shifter.sv | 143 ++++++++++++++
 tb/tb_usr_seq_shifter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// usr_pkg: shared types and constants for the universal sequential shifter.
//   usr_op_e     - 3-bit command opcode
//   usr_state_e  - controller state (IDLE, SHIFT)
//   USR_WIDTH_DEF- default register width
//   is_step_op() - true for opcodes that move bits one position per step
package usr_pkg;

    localparam int USR_WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_SHR  = 3'b001,
        OP_SHL  = 3'b010,
        OP_LOAD = 3'b011,
        OP_ROR  = 3'b100,
        OP_ROL  = 3'b101,
        OP_ASR  = 3'b110,
        OP_CLR  = 3'b111
    } usr_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } usr_state_e;

    // Shift and rotate opcodes run for cmd_amt steps; the rest are one-shot.
    function automatic logic is_step_op(input usr_op_e op);
        return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) ||
               (op == OP_ROL) || (op == OP_ASR);
    endfunction

endpackage

// File: rtl/usr_step.sv
// usr_step: one single-bit shift/rotate step, purely combinational.
//   cur      in  WIDTH  current register contents
//   op       in  3      opcode; non-step opcodes pass cur through unchanged
//   left_in  in  1      serial bit entering at the LSB on SHL
//   right_in in  1      serial bit entering at the MSB on SHR
//   nxt      out WIDTH  register contents after the step
//   bit_out  out 1      bit that left the register on this step
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = USR_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] cur,
    input  usr_op_e          op,
    input  logic             left_in,
    input  logic             right_in,
    output logic [WIDTH-1:0] nxt,
    output logic             bit_out
);

    // Right-moving ops drop cur[0]; left-moving ops drop cur[WIDTH-1].
    // ASR replicates the sign bit and ignores right_in.
    always_comb begin
        nxt     = cur;
        bit_out = 1'b0;
        case (op)
            OP_SHR: begin
                nxt     = {right_in, cur[WIDTH-1:1]};
                bit_out = cur[0];
            end
            OP_SHL: begin
                nxt     = {cur[WIDTH-2:0], left_in};
                bit_out = cur[WIDTH-1];
            end
            OP_ROR: begin
                nxt     = {cur[0], cur[WIDTH-1:1]};
                bit_out = cur[0];
            end
            OP_ROL: begin
                nxt     = {cur[WIDTH-2:0], cur[WIDTH-1]};
                bit_out = cur[WIDTH-1];
            end
            OP_ASR: begin
                nxt     = {cur[WIDTH-1], cur[WIDTH-1:1]};
                bit_out = cur[0];
            end
            default: begin
                nxt     = cur;
                bit_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/usr_seq_shifter.sv
// usr_seq_shifter: universal shift register driven by a valid/ready command
// port. Multi-bit shifts/rotates advance one bit per clock; serial inputs are
// sampled live on every step so a bit stream can be shifted in.
//   clk        in  1      clock
//   clr_n      in  1      asynchronous active-low clear
//   cmd_valid  in  1      command present
//   cmd_ready  out 1      high while IDLE (command accepted on valid&&ready)
//   cmd_op     in  3      opcode (see usr_pkg::usr_op_e)
//   cmd_amt    in  CNT_W  number of single-bit steps for shift/rotate ops
//   data_in    in  WIDTH  LOAD value, sampled at accept
//   right_in   in  1      serial input entering at the MSB on SHR
//   left_in    in  1      serial input entering at the LSB on SHL
//   out        out WIDTH  register contents
//   serial_out out 1      last bit shifted or rotated out
//   busy       out 1      multi-step command in progress
//   done       out 1      one-cycle completion pulse
module usr_seq_shifter
    import usr_pkg::*;
#(
    parameter int WIDTH = USR_WIDTH_DEF,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] data_in,
    input  logic             right_in,
    input  logic             left_in,
    output logic [WIDTH-1:0] out,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] AMT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    usr_state_e       state_q, state_d;
    usr_op_e          op_q, op_d;
    usr_op_e          cmd_op_e;
    usr_op_e          step_op;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             serial_q, serial_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] step_out;
    logic             step_bit;

    assign cmd_op_e = usr_op_e'(cmd_op);

    // The single step unit serves both the accept edge (fresh opcode from the
    // port) and the SHIFT state (opcode latched at accept).
    assign step_op = (state_q == ST_SHIFT) ? op_q : cmd_op_e;

    usr_step #(.WIDTH(WIDTH)) u_step (
        .cur      (out_q),
        .op       (step_op),
        .left_in  (left_in),
        .right_in (right_in),
        .nxt      (step_out),
        .bit_out  (step_bit)
    );

    // Next-state logic. The first step of a shift happens on the accept edge,
    // so rem holds the steps still to go after it; the SHIFT step seen with
    // rem==1 is the last one and returns to IDLE with done.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rem_d    = rem_q;
        out_d    = out_q;
        serial_d = serial_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d = cmd_op_e;
                    if (is_step_op(cmd_op_e)) begin
                        if (cmd_amt == '0) begin
                            done_d = 1'b1;
                        end else begin
                            out_d    = step_out;
                            serial_d = step_bit;
                            if (cmd_amt == AMT_ONE) begin
                                done_d = 1'b1;
                            end else begin
                                rem_d   = cmd_amt - AMT_ONE;
                                state_d = ST_SHIFT;
                            end
                        end
                    end else begin
                        if (cmd_op_e == OP_LOAD) begin
                            out_d = data_in;
                        end else if (cmd_op_e == OP_CLR) begin
                            out_d = '0;
                        end
                        done_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                out_d    = step_out;
                serial_d = step_bit;
                rem_d    = rem_q - AMT_ONE;
                if (rem_q == AMT_ONE) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Clearing mid-shift drops the command outright: no done is produced.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_NOP;
            rem_q    <= '0;
            out_q    <= '0;
            serial_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rem_q    <= rem_d;
            out_q    <= out_d;
            serial_q <= serial_d;
            done_q   <= done_d;
        end
    end

    assign out        = out_q;
    assign serial_out = serial_q;
    assign done       = done_q;
    assign busy       = (state_q == ST_SHIFT);
    assign cmd_ready  = (state_q == ST_IDLE);

endmodule

// File: tb/tb_usr_seq_shifter.sv
// tb_usr_seq_shifter: directed, self-checking bench for usr_seq_shifter at
// WIDTH=8. Inputs change 1ns after a rising edge and outputs are sampled there.
module tb_usr_seq_shifter;
    import usr_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             clr_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [CNT_W-1:0] cmd_amt;
    logic [WIDTH-1:0] data_in;
    logic             right_in;
    logic             left_in;
    logic [WIDTH-1:0] out;
    logic             serial_out;
    logic             busy;
    logic             done;

    int checksTotal  = 0;
    int checksPassed = 0;

    usr_seq_shifter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_amt    (cmd_amt),
        .data_in    (data_in),
        .right_in   (right_in),
        .left_in    (left_in),
        .out        (out),
        .serial_out (serial_out),
        .busy       (busy),
        .done       (done)
    );

    // Free-running 10ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison funnels through here so the counters stay in sync.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checksTotal++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command for a single edge; returns 1ns after the accept edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [CNT_W-1:0] amt,
                                 input logic [WIDTH-1:0] din, input logic lin,
                                 input logic rin);
        cmd_op    = op;
        cmd_amt   = amt;
        data_in   = din;
        left_in   = lin;
        right_in  = rin;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        clr_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_amt   = '0;
        data_in   = '0;
        right_in  = 1'b0;
        left_in   = 1'b0;

        // Reset values while clr_n is low.
        #12;
        checkOutput("rst_out",    32'(out), 32'h00);
        checkOutput("rst_serial", 32'(serial_out), 32'h0);
        checkOutput("rst_busy",   32'(busy), 32'h0);
        checkOutput("rst_done",   32'(done), 32'h0);
        checkOutput("rst_ready",  32'(cmd_ready), 32'h1);
        clr_n = 1'b1;
        tick();

        // 1: clear in the middle of SHL amt=5.
        applyStimulus(OP_LOAD, 4'd0, 8'hAA, 1'b0, 1'b0);
        applyStimulus(OP_SHL, 4'd5, 8'h00, 1'b1, 1'b0);
        checkOutput("s1_step0", 32'(out), 32'h55);
        checkOutput("s1_busy0", 32'(busy), 32'h1);
        tick();
        checkOutput("s1_step1", 32'(out), 32'hAB);
        #3 clr_n = 1'b0;
        #1;
        checkOutput("s1_clr_out",   32'(out), 32'h00);
        checkOutput("s1_clr_busy",  32'(busy), 32'h0);
        checkOutput("s1_clr_ready", 32'(cmd_ready), 32'h1);
        checkOutput("s1_clr_done",  32'(done), 32'h0);
        #2 clr_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("s1_no_done", 32'(done), 32'h0);
            checkOutput("s1_out_held", 32'(out), 32'h00);
        end

        // 2: LOAD latency 1, single-cycle done, never busy.
        applyStimulus(OP_LOAD, 4'd0, 8'h73, 1'b0, 1'b0);
        checkOutput("s2_out",  32'(out), 32'h73);
        checkOutput("s2_done", 32'(done), 32'h1);
        checkOutput("s2_busy", 32'(busy), 32'h0);
        tick();
        checkOutput("s2_done_low", 32'(done), 32'h0);

        // 3: SHR amt=3 with right_in=1 from 0x73.
        applyStimulus(OP_SHR, 4'd3, 8'h00, 1'b0, 1'b1);
        checkOutput("s3_e0_out",  32'(out), 32'hB9);
        checkOutput("s3_e0_busy", 32'(busy), 32'h1);
        checkOutput("s3_e0_done", 32'(done), 32'h0);
        tick();
        checkOutput("s3_e1_out",  32'(out), 32'hDC);
        checkOutput("s3_e1_busy", 32'(busy), 32'h1);
        tick();
        checkOutput("s3_e2_out",    32'(out), 32'hEE);
        checkOutput("s3_e2_busy",   32'(busy), 32'h0);
        checkOutput("s3_e2_done",   32'(done), 32'h1);
        checkOutput("s3_e2_serial", 32'(serial_out), 32'h0);
        tick();
        checkOutput("s3_done_low", 32'(done), 32'h0);

        // 4: ROL amt=8 returns to the start value; ROR amt=0 is a no-op with done.
        applyStimulus(OP_LOAD, 4'd0, 8'h73, 1'b0, 1'b0);
        applyStimulus(OP_ROL, 4'd8, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            checkOutput("s4_busy", 32'(busy), 32'h1);
            checkOutput("s4_nodone", 32'(done), 32'h0);
            tick();
        end
        checkOutput("s4_out",  32'(out), 32'h73);
        checkOutput("s4_done", 32'(done), 32'h1);
        checkOutput("s4_busy_end", 32'(busy), 32'h0);
        // Last step rotated out bit7 of 0xB9.
        checkOutput("s4_serial", 32'(serial_out), 32'h1);
        applyStimulus(OP_ROR, 4'd0, 8'h00, 1'b0, 1'b0);
        checkOutput("s4_ror0_out",    32'(out), 32'h73);
        checkOutput("s4_ror0_done",   32'(done), 32'h1);
        checkOutput("s4_ror0_busy",   32'(busy), 32'h0);
        checkOutput("s4_ror0_serial", 32'(serial_out), 32'h1);

        // 5: ASR keeps the sign; SHL past WIDTH drains to zero.
        applyStimulus(OP_LOAD, 4'd0, 8'h80, 1'b0, 1'b0);
        applyStimulus(OP_ASR, 4'd2, 8'h00, 1'b0, 1'b0);
        checkOutput("s5_asr_e0", 32'(out), 32'hC0);
        tick();
        checkOutput("s5_asr_out",  32'(out), 32'hE0);
        checkOutput("s5_asr_done", 32'(done), 32'h1);
        applyStimulus(OP_LOAD, 4'd0, 8'hFF, 1'b0, 1'b0);
        checkOutput("s5_load_serial_held", 32'(serial_out), 32'h0);
        applyStimulus(OP_SHL, 4'd9, 8'h00, 1'b0, 1'b0);
        checkOutput("s5_shl_e0", 32'(out), 32'hFE);
        checkOutput("s5_shl_e0_serial", 32'(serial_out), 32'h1);
        for (int i = 0; i < 8; i++) tick();
        checkOutput("s5_shl_out",    32'(out), 32'h00);
        checkOutput("s5_shl_serial", 32'(serial_out), 32'h0);
        checkOutput("s5_shl_done",   32'(done), 32'h1);

        // 6: a LOAD held valid during SHR amt=4 waits for the done cycle.
        applyStimulus(OP_SHR, 4'd4, 8'h00, 1'b0, 1'b1);
        checkOutput("s6_e0_out", 32'(out), 32'h80);
        cmd_op    = OP_LOAD;
        data_in   = 8'h55;
        cmd_valid = 1'b1;
        tick();
        checkOutput("s6_e1_out",   32'(out), 32'hC0);
        checkOutput("s6_e1_ready", 32'(cmd_ready), 32'h0);
        tick();
        checkOutput("s6_e2_out", 32'(out), 32'hE0);
        tick();
        checkOutput("s6_e3_out",   32'(out), 32'hF0);
        checkOutput("s6_e3_done",  32'(done), 32'h1);
        checkOutput("s6_e3_ready", 32'(cmd_ready), 32'h1);
        tick();
        cmd_valid = 1'b0;
        checkOutput("s6_load_out",  32'(out), 32'h55);
        checkOutput("s6_load_done", 32'(done), 32'h1);
        checkOutput("s6_load_busy", 32'(busy), 32'h0);
        tick();
        checkOutput("s6_idle_done", 32'(done), 32'h0);
        checkOutput("s6_idle_out",  32'(out), 32'h55);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
